pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Stall/flush controller for the 5-stage pipeline. Generates the write enables (PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite) and flush strobes for the pipeline registers. Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits. Includes a bounded wait timer that reports hung memory accesses.

## Interface
- MEM_TIMEOUT, 16: max wait cycles for one DM access before abort; legal range 1..255.
- clk  in  1  pipeline clock; state and counters update on negedge clk, same edge as the pipeline registers.
- rst  in  1  reset, asynchronous, active-high.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_WR_out  in  5  destination register of the instruction in EX.
- EX_Branch_taken  in  1  branch in EX resolved taken.
- M_MemAccess  in  1  instruction in M reads or writes DM.
- DM_ready  in  1  DM completes the current access this cycle; may be combinational from DM_req.
- DM_req  out  1  DM access request.
- PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite  out  1 each  pipeline register enables.
- IF_ID_flush, ID_EX_flush  out  1 each  load a bubble (all-zero control) into that register.
- mem_err  out  1  sticky; a DM access exceeded MEM_TIMEOUT.

## Operation
- States: RUN, LU_STALL, MEM_WAIT. Outputs are combinational from state and inputs.
- Priority in RUN: memory wait > branch flush > load-use.
- Memory wait
  - In RUN, M_MemAccess=1 and DM_ready=0: freeze all five enables to 0, no flushes, and go to MEM_WAIT.
  - DM_req = M_MemAccess in RUN and MEM_WAIT.
  - A frozen M_WB makes the WB instruction rewrite the same register with the same value; this is idempotent and accepted.
- In MEM_WAIT:
  - Enables stay 0 and wait_cnt increments.
  - DM_ready=1: enables return to 1 in that cycle, wait_cnt is cleared, go to RUN.
  - wait_cnt reaches MEM_TIMEOUT with DM_ready still 0: set mem_err, release as if DM_ready, go to RUN; the load result is undefined.
- Branch, RUN, no memory wait, EX_Branch_taken=1:
  - All enables 1 (PC loads the target), IF_ID_flush=1, ID_EX_flush=1.
  - A simultaneous load-use match is ignored, since the ID instruction is squashed.
- Load-use, RUN: EX_MemRead=1, EX_WR_out!=0, and EX_WR_out==ID_rs or EX_WR_out==ID_rt.
  - PCWrite=0, IF_IDWrite=0, ID_EX_flush=1, other enables 1; go to LU_STALL.
- LU_STALL:
  - Exactly one cycle; the load is now in M and forwarding covers the dependency.
  - All enables 1, no flushes, go to RUN.
  - If M_MemAccess=1 and DM_ready=0, memory-wait rules apply instead (freeze, go to MEM_WAIT).
- Otherwise in RUN: all enables 1, flushes 0.
- mem_err clears only on rst.

## Timing
- While rst=1: all enables 0, flushes 0, DM_req 0, mem_err 0, wait_cnt 0, state RUN.
  - After release, outputs follow RUN rules combinationally.
- rst asserted mid-MEM_WAIT: the access is abandoned immediately; DM_req drops asynchronously.
- Zero-wait DM (DM_ready high in the request cycle): no stall cycle.
- Load-use costs exactly 1 bubble. Taken branch costs 2 squashed slots. Memory wait costs N cycles for DM_ready after N cycles, capped at MEM_TIMEOUT.
- Next state is registered on negedge clk. Inputs must settle before negedge, which matches the pipeline register setup requirement.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both 0 on rst and wrapping at 2^32.
  - stall_cnt counts negedges with PCWrite=0.
  - flush_cnt counts negedges with IF_ID_flush=1.
- PIPE_HAZARD_CTRL_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Load-use: EX_MemRead=1, EX_WR_out=5, ID_rs=5 -> one cycle with PCWrite=0, IF_IDWrite=0, ID_EX_flush=1; next cycle all enables 1. Repeat with EX_WR_out=0 -> no stall.
- Branch + hazard: EX_Branch_taken=1 with a load-use match -> IF_ID_flush=ID_EX_flush=1, PCWrite=1, state stays RUN.
- DM wait: M_MemAccess=1 with DM_ready low for 3 cycles -> enables 0 for exactly 3 cycles and 1 in the DM_ready cycle; DM_req high throughout.
- Timeout: MEM_TIMEOUT=4, DM_ready never asserts -> mem_err=1 after 4 wait cycles, pipeline released, mem_err held until rst.
- Reset mid-wait: assert rst during MEM_WAIT -> DM_req, enables and mem_err go to 0 immediately; after release, state is RUN.
- PERF_EN: one load-use, one taken branch and a 3-cycle DM wait -> stall_cnt=4, flush_cnt=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// Handles load-use stalls, taken-branch squashes and multi-cycle data-memory
// waits, including a bounded wait timer that flags hung DM accesses.
// State and counters update on negedge clk, the same edge as the pipeline
// registers. All outputs are combinational from state and inputs.
//
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN adds the stall_cnt and
// flush_cnt performance counters.
//
// Handshake: DM_req is raised whenever the instruction in M accesses DM.
// The access completes in any cycle where DM_req and DM_ready are both 1.
// DM_ready may depend combinationally on DM_req. Until the access completes
// the pipeline is frozen (all register enables 0).
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_WR_out,
    input  logic        EX_Branch_taken,
    input  logic        M_MemAccess,
    input  logic        DM_ready,
    output logic        DM_req,
    output logic        PCWrite,
    output logic        IF_IDWrite,
    output logic        ID_EXWrite,
    output logic        EX_MWrite,
    output logic        M_WBWrite,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        mem_err,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    logic [1:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic load_use;
    logic mem_stall;
    logic front_en;   // PC and IF/ID
    logic back_en;    // ID/EX, EX/M, M/WB
    logic if_id_fl;
    logic id_ex_fl;
    logic dm_req_c;

    // Next-state and output decode; priority in RUN is memory wait, then
    // taken branch (which squashes the ID instruction, so any load-use match
    // is moot), then load-use.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        front_en   = 1'b1;
        back_en    = 1'b1;
        if_id_fl   = 1'b0;
        id_ex_fl   = 1'b0;
        dm_req_c   = M_MemAccess;

        load_use  = EX_MemRead && (EX_WR_out != 5'd0) &&
                    ((EX_WR_out == ID_rs) || (EX_WR_out == ID_rt));
        mem_stall = M_MemAccess && !DM_ready;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    front_en   = 1'b0;
                    back_en    = 1'b0;
                    wait_cnt_d = 8'd1;
                    state_d    = ST_MEM_WAIT;
                end else if (EX_Branch_taken) begin
                    if_id_fl = 1'b1;
                    id_ex_fl = 1'b1;
                end else if (load_use) begin
                    front_en = 1'b0;
                    id_ex_fl = 1'b1;
                    state_d  = ST_LU_STALL;
                end
            end
            ST_LU_STALL: begin
                // The load has reached M; forwarding resolves the dependency.
                if (mem_stall) begin
                    front_en   = 1'b0;
                    back_en    = 1'b0;
                    wait_cnt_d = 8'd1;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // wait_cnt_q holds the number of frozen cycles already spent.
                if (DM_ready) begin
                    wait_cnt_d = 8'd0;
                    state_d    = ST_RUN;
                end else if (wait_cnt_q >= TIMEOUT_C) begin
                    // Give up: release the pipeline; load data is undefined.
                    mem_err_d  = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = ST_RUN;
                end else begin
                    front_en   = 1'b0;
                    back_en    = 1'b0;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                wait_cnt_d = 8'd0;
                state_d    = ST_RUN;
            end
        endcase

        // Reset quiesces everything immediately, abandoning any DM access.
        if (rst) begin
            front_en = 1'b0;
            back_en  = 1'b0;
            if_id_fl = 1'b0;
            id_ex_fl = 1'b0;
            dm_req_c = 1'b0;
        end
    end

    assign DM_req      = dm_req_c;
    assign PCWrite     = front_en;
    assign IF_IDWrite  = front_en;
    assign ID_EXWrite  = back_en;
    assign EX_MWrite   = back_en;
    assign M_WBWrite   = back_en;
    assign IF_ID_flush = if_id_fl;
    assign ID_EX_flush = id_ex_fl;
    assign mem_err     = mem_err_q;
    assign dbg_state_o = state_q;

    // Controller state registers, updated with the pipeline registers.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Performance counters: front-end stall cycles and branch squashes.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!front_en) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (if_id_fl)  flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. The driver applies one vector per
// cycle after posedge and queues its expected response; the monitor samples
// the DUT mid-cycle (before the negedge update) and checks against the queue.
// Expected word: {DM_req, PC, IF_ID, ID_EX, EX_M, M_WB enables,
//                 IF_ID_flush, ID_EX_flush, mem_err, state}.
module tb_pipe_hazard_ctrl;

    localparam logic [1:0] RUN = 2'd0;
    localparam logic [1:0] LU  = 2'd1;
    localparam logic [1:0] MW  = 2'd2;
    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] LUE = 5'b00111;
    localparam logic [4:0] FRZ = 5'b00000;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_rs, ID_rt, EX_WR_out;
    logic        EX_MemRead, EX_Branch_taken, M_MemAccess, DM_ready;
    logic        DM_req, PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite;
    logic        IF_ID_flush, ID_EX_flush, mem_err;
    logic [1:0]  dbg_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    logic [10:0] exp_q[$];
    string       name_q[$];
    int          n_vec;
    int          n_err;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk),
        .rst(rst),
        .ID_rs(ID_rs),
        .ID_rt(ID_rt),
        .EX_MemRead(EX_MemRead),
        .EX_WR_out(EX_WR_out),
        .EX_Branch_taken(EX_Branch_taken),
        .M_MemAccess(M_MemAccess),
        .DM_ready(DM_ready),
        .DM_req(DM_req),
        .PCWrite(PCWrite),
        .IF_IDWrite(IF_IDWrite),
        .ID_EXWrite(ID_EXWrite),
        .EX_MWrite(EX_MWrite),
        .M_WBWrite(M_WBWrite),
        .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush),
        .mem_err(mem_err),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
`endif
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [10:0] mk(input logic req, input logic [4:0] en,
                                       input logic [1:0] fl, input logic err,
                                       input logic [1:0] st);
        return {req, en, fl, err, st};
    endfunction

    // Driver: one vector per cycle, applied just after posedge
    task automatic apply(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] wr, input logic br,
                         input logic ma, input logic rdy, input logic [10:0] e,
                         input string nm);
        @(posedge clk);
        rst             = r;
        ID_rs           = rs;
        ID_rt           = rt;
        EX_MemRead      = mr;
        EX_WR_out       = wr;
        EX_Branch_taken = br;
        M_MemAccess     = ma;
        DM_ready        = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor / scoreboard: compare mid-cycle, before the negedge update
    always @(posedge clk) begin
        logic [10:0] got, want;
        string       nm;
        #2;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {DM_req, PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite,
                    IF_ID_flush, ID_EX_flush, mem_err, dbg_state};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got %b required %b", nm, got, want);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        ID_rs = '0; ID_rt = '0; EX_WR_out = '0;
        EX_MemRead = 1'b0; EX_Branch_taken = 1'b0;
        M_MemAccess = 1'b0; DM_ready = 1'b0;

        //     rst rs  rt  mr wr  br ma rdy expected
        apply(1, 5,  5,  1, 5,  1, 1, 0, mk(0, FRZ, 2'b00, 0, RUN), "reset");
        apply(0, 0,  0,  0, 0,  0, 0, 0, mk(0, ALL, 2'b00, 0, RUN), "idle");
        // load-use on rs, then the single stall cycle with a zero-wait DM access
        apply(0, 5,  0,  1, 5,  0, 0, 0, mk(0, LUE, 2'b01, 0, RUN), "lu_rs");
        apply(0, 5,  0,  0, 0,  0, 1, 1, mk(1, ALL, 2'b00, 0, LU),  "lu_stall");
        apply(0, 0,  0,  0, 0,  0, 0, 0, mk(0, ALL, 2'b00, 0, RUN), "post_lu");
        apply(0, 0,  0,  1, 0,  0, 0, 0, mk(0, ALL, 2'b00, 0, RUN), "lu_r0");
        // load-use on rt, then a DM wait starting in the stall cycle
        apply(0, 3,  7,  1, 7,  0, 0, 0, mk(0, LUE, 2'b01, 0, RUN), "lu_rt");
        apply(0, 3,  7,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, LU),  "lu_then_dm");
        apply(0, 3,  7,  0, 0,  0, 1, 1, mk(1, ALL, 2'b00, 0, MW),  "lu_dm_rdy");
        // taken branch overrides load-use
        apply(0, 5,  0,  1, 5,  1, 0, 0, mk(0, ALL, 2'b11, 0, RUN), "br_lu");
        apply(0, 0,  0,  0, 0,  0, 0, 0, mk(0, ALL, 2'b00, 0, RUN), "post_br");
        // 3-cycle DM wait; memory wait beats branch in the first cycle
        apply(0, 5,  0,  1, 5,  1, 1, 0, mk(1, FRZ, 2'b00, 0, RUN), "dm_over_br");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, MW),  "dm_w2");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, MW),  "dm_w3");
        apply(0, 0,  0,  0, 0,  0, 1, 1, mk(1, ALL, 2'b00, 0, MW),  "dm_rdy");
        apply(0, 0,  0,  0, 0,  0, 1, 1, mk(1, ALL, 2'b00, 0, RUN), "zero_wait");
        // timeout at 4 frozen cycles
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, RUN), "to_w1");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, MW),  "to_w2");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, MW),  "to_w3");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, MW),  "to_w4");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, ALL, 2'b00, 0, MW),  "to_release");
        apply(0, 0,  0,  0, 0,  0, 0, 0, mk(0, ALL, 2'b00, 1, RUN), "err_set");
        apply(0, 9,  0,  1, 9,  0, 0, 0, mk(0, LUE, 2'b01, 1, RUN), "err_lu");
        apply(0, 0,  0,  0, 0,  0, 0, 0, mk(0, ALL, 2'b00, 1, LU),  "err_held");
        // reset during a DM wait
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 1, RUN), "rw_w1");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 1, MW),  "rw_w2");
        apply(1, 0,  0,  0, 0,  0, 1, 0, mk(0, FRZ, 2'b00, 0, RUN), "rw_rst");
        apply(0, 0,  0,  0, 0,  0, 0, 0, mk(0, ALL, 2'b00, 0, RUN), "rw_post");
        // load-use + taken branch + 3-cycle DM wait
        apply(0, 4,  0,  1, 4,  0, 0, 0, mk(0, LUE, 2'b01, 0, RUN), "pf_lu");
        apply(0, 0,  0,  0, 0,  0, 0, 0, mk(0, ALL, 2'b00, 0, LU),  "pf_lus");
        apply(0, 0,  0,  0, 0,  1, 0, 0, mk(0, ALL, 2'b11, 0, RUN), "pf_br");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, RUN), "pf_w1");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, MW),  "pf_w2");
        apply(0, 0,  0,  0, 0,  0, 1, 0, mk(1, FRZ, 2'b00, 0, MW),  "pf_w3");
        apply(0, 0,  0,  0, 0,  0, 1, 1, mk(1, ALL, 2'b00, 0, MW),  "pf_rdy");
        apply(0, 0,  0,  0, 0,  0, 0, 0, mk(0, ALL, 2'b00, 0, RUN), "pf_idle");
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        #3;
        n_vec++;
        if (stall_cnt !== 32'd4) begin
            n_err++;
            $display("FAIL stall_cnt: got %0d required 4", stall_cnt);
        end
        n_vec++;
        if (flush_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL flush_cnt: got %0d required 1", flush_cnt);
        end
`endif

        // Drain: every queued vector must have been checked
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err += exp_q.size();
            $display("FAIL drain: got %0d unchecked vectors required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
